int_sched: RTL

Vectored, level-programmable interrupt scheduler for the 68000 bus. Latches rising edges on up to eight peripheral interrupt lines and assigns each source a programmable priority level (0–7). It drives the arbitrated level onto `ipl_n` and answers the CPU interrupt-acknowledge cycle with a per-source vector. It is a memory-mapped slave on the same 16-bit peripheral bus as the other register blocks, and it replaces the fixed-level autovector scheme with a scheduled one.

---
 rtl/int_sched.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/int_sched.sv
// Vectored interrupt scheduler for the 68000 bus: edge capture, programmable levels,
// arbitrated IPL output and per-source IACK vectors behind a 16-bit register slave.
module int_sched #(
  parameter int unsigned NSRC    = 8,
  parameter logic [7:0]  VEC_RST = 8'h40
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic [15:0]     i_data_write,
  output logic [15:0]     o_data_read,
  input  logic [7:0]      i_addr,
  input  logic            i_uds,
  input  logic            i_lds,
  input  logic            i_rw,
  input  logic            i_as,
  output logic            o_ack,
  input  logic            i_iack,
  input  logic [2:0]      i_iack_level,
  input  logic [NSRC-1:0] i_irq,
  output logic [2:0]      o_ipl_n
);

  typedef enum logic [1:0] {StIdle, StAck, StHold} state_t;

  state_t          r_state, w_state_d;
  logic            r_gen, w_gen_d;
  logic [NSRC-1:0] r_en, w_en_d, r_pend, w_pend_d, r_insv, w_insv_d, r_irq_prev;
  logic [2:0]      r_lvl [NSRC];
  logic [2:0]      w_lvl_d [NSRC];
  logic [7:0]      r_vbase, w_vbase_d;

  // Request fields captured when the access is accepted in StIdle
  logic [6:0]      r_word;
  logic            r_uds, r_lds, r_rw, r_iack;
  logic [2:0]      r_iack_level;
  logic [15:0]     r_wdata;

  logic            r_ack;
  logic [15:0]     r_data_read, w_data_read_d;
  logic [2:0]      r_ipl_n, w_ipl_n_d;

  logic [NSRC-1:0] w_rise, w_pend_w1c, w_insv_w1c, w_iack_clr;
  logic [2:0]      w_win_lvl, w_iack_idx;
  logic            w_iack_hit;
  logic            w_do, w_do_iack, w_do_wr;
  logic [15:0]     w_lvl0_rd, w_lvl1_rd;
  logic            w_unused;

  assign w_unused = ^{i_addr[0], r_wdata};

  // Descending scan: ties on level and IACK matches resolve to the lowest index
  always_comb begin
    logic c;
    w_win_lvl  = '0;
    w_iack_hit = 1'b0;
    w_iack_idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      c = r_pend[i] & r_en[i] & (r_lvl[i] != 3'd0);
      if (c && (r_lvl[i] >= w_win_lvl)) w_win_lvl = r_lvl[i];
      if (c && (r_lvl[i] == r_iack_level)) begin
        w_iack_hit = 1'b1;
        w_iack_idx = 3'(i);
      end
    end
    w_ipl_n_d = (r_gen && (w_win_lvl != 3'd0)) ? ~w_win_lvl : 3'b111;
  end

  always_comb begin
    w_lvl0_rd = '0;
    w_lvl1_rd = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (i < 4) w_lvl0_rd[(i % 4) * 4 +: 3] = r_lvl[i];
      else       w_lvl1_rd[(i % 4) * 4 +: 3] = r_lvl[i];
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (i_as) w_state_d = StAck;
      StAck:   w_state_d = StHold;
      StHold:  if (!i_as) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase

    w_do      = (r_state == StAck);
    w_do_iack = w_do & r_iack;
    w_do_wr   = w_do & ~r_iack & ~r_rw;

    w_rise     = i_irq & ~r_irq_prev & r_en;
    w_pend_w1c = (w_do_wr && r_word == 7'd2 && r_lds) ? r_wdata[NSRC-1:0] : '0;
    w_insv_w1c = (w_do_wr && r_word == 7'd6 && r_lds) ? r_wdata[NSRC-1:0] : '0;
    for (int i = 0; i < NSRC; i++) begin
      w_iack_clr[i] = w_do_iack & w_iack_hit & (w_iack_idx == 3'(i));
    end
    // A new edge outranks both clears; the IACK set outranks an EOI write
    w_pend_d = (r_pend & ~w_pend_w1c & ~w_iack_clr) | w_rise;
    w_insv_d = (r_insv & ~w_insv_w1c) | w_iack_clr;

    w_gen_d   = (w_do_wr && r_word == 7'd0 && r_lds) ? r_wdata[0] : r_gen;
    w_en_d    = (w_do_wr && r_word == 7'd1 && r_lds) ? r_wdata[NSRC-1:0] : r_en;
    w_vbase_d = (w_do_wr && r_word == 7'd5 && r_lds) ? r_wdata[7:0] : r_vbase;
    w_lvl_d   = r_lvl;
    for (int i = 0; i < NSRC; i++) begin
      if (w_do_wr && (r_word == 7'(3 + i / 4)) && (((i % 4) < 2) ? r_lds : r_uds)) begin
        w_lvl_d[i] = r_wdata[(i % 4) * 4 +: 3];
      end
    end

    w_data_read_d = '0;
    if (w_do_iack) begin
      w_data_read_d = w_iack_hit ? {8'h00, r_vbase + {5'b00000, w_iack_idx}} : 16'h0018;
    end else if (w_do && r_rw) begin
      case (r_word)
        7'd0:    w_data_read_d = {15'b0, r_gen};
        7'd1:    w_data_read_d = 16'(r_en);
        7'd2:    w_data_read_d = 16'(r_pend);
        7'd3:    w_data_read_d = w_lvl0_rd;
        7'd4:    w_data_read_d = w_lvl1_rd;
        7'd5:    w_data_read_d = {8'h00, r_vbase};
        7'd6:    w_data_read_d = 16'(r_insv);
        default: w_data_read_d = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= StIdle;
      r_gen        <= 1'b0;
      r_en         <= '0;
      r_pend       <= '0;
      r_insv       <= '0;
      r_irq_prev   <= '0;
      r_lvl        <= '{default: '0};
      r_vbase      <= VEC_RST;
      r_word       <= '0;
      r_uds        <= 1'b0;
      r_lds        <= 1'b0;
      r_rw         <= 1'b0;
      r_iack       <= 1'b0;
      r_iack_level <= '0;
      r_wdata      <= '0;
      r_ack        <= 1'b0;
      r_data_read  <= '0;
      r_ipl_n      <= 3'b111;
    end else begin
      r_state    <= w_state_d;
      r_gen      <= w_gen_d;
      r_en       <= w_en_d;
      r_pend     <= w_pend_d;
      r_insv     <= w_insv_d;
      r_irq_prev <= i_irq;
      r_lvl      <= w_lvl_d;
      r_vbase    <= w_vbase_d;
      if (r_state == StIdle && i_as) begin
        r_word       <= i_addr[7:1];
        r_uds        <= i_uds;
        r_lds        <= i_lds;
        r_rw         <= i_rw;
        r_iack       <= i_iack;
        r_iack_level <= i_iack_level;
        r_wdata      <= i_data_write;
      end
      r_ack       <= w_do;
      r_data_read <= w_data_read_d;
      r_ipl_n     <= w_ipl_n_d;
    end
  end

  assign o_ack       = r_ack;
  assign o_data_read = r_data_read;
  assign o_ipl_n     = r_ipl_n;

endmodule
